// File: rtl/fc_layer_stream.sv
// fc_layer_stream: runtime-loadable fully-connected layer, y = act(W*x + b).
// Weights and biases arrive on a load stream, x elements on an input stream,
// and results leave on an output stream, all valid/ready.
// P lanes compute P output rows at once; each group of rows takes N+2 cycles
// to the first result, then drains one lane per output handshake.
// Build option: define FC_RELU_EN to clamp negative results to zero (ReLU);
// leave it undefined for a plain linear layer.
module fc_layer_stream #(
  parameter int M    = 8,
  parameter int N    = 4,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int FRAC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic signed [T-1:0] w_data,
  input  logic                reload,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data
);

  localparam int ACC_W = 2 * T + $clog2(N) + 1;
  localparam int G     = M / P;
  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int XW    = $clog2(N);
  localparam int CW    = $clog2(N + 1);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int LW    = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {LOAD_W, LOAD_X, MAC, DRAIN} state_t;

  state_t                  state;
  logic [RW-1:0]           w_row;
  logic [XW-1:0]           w_col;
  logic                    bias_phase;
  logic [XW-1:0]           x_cnt;
  logic [GW-1:0]           g;
  logic [CW-1:0]           mac_cnt;
  logic [LW-1:0]           lane;
  logic signed [ACC_W-1:0] acc [P];
  logic signed [T-1:0]     w_rd [P];
  logic signed [T-1:0]     x_rd;
  logic signed [T-1:0]     w_mem [M][N];
  logic signed [T-1:0]     b_mem [M];
  logic signed [T-1:0]     x_mem [N];

  logic w_fire, x_fire, reload_take;

  assign w_fire      = w_valid && w_ready;
  assign reload_take = reload && (x_cnt == '0);
  assign x_fire      = input_valid && input_ready && !reload_take;

  // Output row handled by lane p while working on group gi.
  function automatic logic [RW-1:0] row_of(input logic [GW-1:0] gi, input int p);
    return RW'(int'(gi) * P + p);
  endfunction

  // Bias aligned to the accumulator's binary point.
  function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [T-1:0] b);
    logic signed [ACC_W-1:0] e;
    e = {{(ACC_W-T){b[T-1]}}, b};
    return e <<< FRAC;
  endfunction

  // Full-precision product, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] term(input logic signed [T-1:0] a,
                                                   input logic signed [T-1:0] b);
    logic signed [2*T-1:0] pr;
    pr = $signed({{T{a[T-1]}}, a}) * $signed({{T{b[T-1]}}, b});
    return {{(ACC_W-2*T){pr[2*T-1]}}, pr};
  endfunction

  // Rescale, saturate to T bits and apply the optional activation.
  function automatic logic signed [T-1:0] finish(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic signed [T-1:0]     r;
    s = a >>> FRAC;
    if ((&s[ACC_W-1:T-1]) || !(|s[ACC_W-1:T-1])) r = s[T-1:0];
    else if (s[ACC_W-1])                         r = {1'b1, {(T-1){1'b0}}};
    else                                         r = {1'b0, {(T-1){1'b1}}};
`ifdef FC_RELU_EN
    if (r[T-1]) r = '0;
`endif
    return r;
  endfunction

  // Storage writes and synchronous operand reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_fire && !bias_phase) w_mem[w_row][w_col] <= w_data;
    if (reset && w_fire && bias_phase)  b_mem[w_row] <= w_data;
    if (reset && x_fire)                x_mem[x_cnt] <= input_data;
    if (state == MAC && mac_cnt < CW'(N)) begin
      x_rd <= x_mem[mac_cnt[XW-1:0]];
      for (int p = 0; p < P; p++) w_rd[p] <= w_mem[row_of(g, p)][mac_cnt[XW-1:0]];
    end
  end

  // Control FSM: load, accumulate per group, drain lanes in order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD_W;
      w_ready      <= 1'b1;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= '0;
      w_row        <= '0;
      w_col        <= '0;
      bias_phase   <= 1'b0;
      x_cnt        <= '0;
      g            <= '0;
      mac_cnt      <= '0;
      lane         <= '0;
      for (int p = 0; p < P; p++) acc[p] <= '0;
    end else begin
      case (state)
        LOAD_W: begin
          if (w_fire) begin
            if (!bias_phase) begin
              if (w_col == XW'(N - 1)) begin
                w_col <= '0;
                if (w_row == RW'(M - 1)) begin
                  w_row      <= '0;
                  bias_phase <= 1'b1;
                end else begin
                  w_row <= w_row + RW'(1);
                end
              end else begin
                w_col <= w_col + XW'(1);
              end
            end else if (w_row == RW'(M - 1)) begin
              w_row       <= '0;
              bias_phase  <= 1'b0;
              w_ready     <= 1'b0;
              input_ready <= 1'b1;
              x_cnt       <= '0;
              state       <= LOAD_X;
            end else begin
              w_row <= w_row + RW'(1);
            end
          end
        end
        LOAD_X: begin
          if (reload_take) begin
            state       <= LOAD_W;
            w_ready     <= 1'b1;
            input_ready <= 1'b0;
            w_row       <= '0;
            w_col       <= '0;
            bias_phase  <= 1'b0;
          end else if (x_fire) begin
            if (x_cnt == XW'(N - 1)) begin
              x_cnt       <= '0;
              input_ready <= 1'b0;
              g           <= '0;
              mac_cnt     <= '0;
              state       <= MAC;
              for (int p = 0; p < P; p++) acc[p] <= bias_ext(b_mem[row_of('0, p)]);
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end
        end
        MAC: begin
          if (mac_cnt != '0)
            for (int p = 0; p < P; p++) acc[p] <= acc[p] + term(w_rd[p], x_rd);
          if (mac_cnt == CW'(N)) begin
            state <= DRAIN;
            lane  <= '0;
          end
          mac_cnt <= mac_cnt + CW'(1);
        end
        DRAIN: begin
          if (!output_valid) begin
            output_valid <= 1'b1;
            output_data  <= finish(acc[lane]);
          end else if (output_ready) begin
            if (lane == LW'(P - 1)) begin
              output_valid <= 1'b0;
              if (g == GW'(G - 1)) begin
                g           <= '0;
                x_cnt       <= '0;
                input_ready <= 1'b1;
                state       <= LOAD_X;
              end else begin
                g       <= g + GW'(1);
                mac_cnt <= '0;
                state   <= MAC;
                for (int p = 0; p < P; p++) acc[p] <= bias_ext(b_mem[row_of(g + GW'(1), p)]);
              end
            end else begin
              lane        <= lane + LW'(1);
              output_data <= finish(acc[lane + LW'(1)]);
            end
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: doc/fc_layer_stream.md
# fc_layer_stream

Runtime-loadable fully-connected layer computing y = act(W·x + b) over M outputs and N inputs, with P parallel MAC lanes.
- Successor to the fixed-size, ROM-weighted FC layers. Weights and biases arrive over a load stream, so no weight regeneration per network.
- Adds fixed-point scaling, bias, saturation and an optional ReLU.
- Sits between adjacent layers in the generated network, valid/ready on every stream.

## Interface
- M, 8: output neurons; M % P == 0
- N, 4: input vector length, ≥ 2
- T, 16: signed data/weight/bias width
- P, 2: parallel MAC lanes (rows computed concurrently)
- FRAC, 0: fractional bits; the accumulator is arithmetically shifted right by FRAC before saturation
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low (asserted when 0)
- w_valid  in  1  weight/bias word valid
- w_ready  out  1  block accepts weight/bias word
- w_data  in  T  signed weight/bias word
- reload  in  1  request re-entry to weight load
- input_valid  in  1  x element valid
- input_ready  out  1  block accepts x element
- input_data  in  T  signed x element
- output_valid  out  1  y element valid
- output_ready  in  1  downstream accepts y element
- output_data  out  T  signed y element

## Operation
- States: LOAD_W, LOAD_X, MAC, DRAIN.
- LOAD_W:
  - w_ready=1. Accepts M·N weights row-major (word k → W[k/N][k%N]), then M biases b[0..M-1].
  - After the last bias handshake, go to LOAD_X.
- LOAD_X:
  - input_ready=1. Accepts N elements x[0..N-1] into the x buffer.
  - After the N-th handshake, go to MAC with group g=0.
  - reload=1 with zero elements accepted in the current vector: go to LOAD_W next cycle; the x element on that cycle is not accepted.
  - reload is ignored once any element of the vector has been accepted.
- MAC:
  - For group g, lane p computes row r=g·P+p.
  - acc_p = (b[r] <<< FRAC) + Σ_n W[r][n]·x[n].
  - Weight and x memories are synchronous-read, 1-cycle latency.
  - Go to DRAIN when all N products are accumulated.
- DRAIN:
  - Emit lanes p=0..P-1 in order, one per output handshake.
  - After the last lane: if g < M/P−1, go to MAC with g+1; otherwise go to LOAD_X.
- Arithmetic:
  - Products are 2T bits. Accumulator ACC_W = 2T + clog2(N) + 1 bits, sign-extended, never wraps.
  - Result: acc >>> FRAC (arithmetic), then saturate to [−2^(T−1), 2^(T−1)−1].
- Output order: y[0], y[1], …, y[M−1] per input vector.
- Weights and biases persist across vectors until the next LOAD_W.

## Timing
- Reset values:
  - state=LOAD_W; w_ready=1; input_ready=0; output_valid=0; output_data=0.
  - Internal counters are 0. Weight/x RAM contents are not cleared.
- Reset mid-operation (any state): next cycle state is as above. The in-flight vector and results are discarded, and weights must be reloaded.
- Handshakes:
  - Transfer occurs when valid && ready on a rising edge.
  - w_ready, input_ready and output_valid are registered outputs.
  - input_ready=0 outside LOAD_X; w_ready=0 outside LOAD_W.
- output_data and output_valid are held stable while output_valid && !output_ready.
- Latency:
  - First output_valid: N+2 cycles after the final x handshake.
  - Each subsequent group: N+2 cycles after the last DRAIN handshake of the previous group.
- With output_ready=1 constantly, one vector takes M/P·(N+2+P) cycles after x load completes, +1 to return to LOAD_X.
- input_ready reasserts the cycle after the last y handshake. No overlap of x loading with compute.

## Configuration
- FC_RELU_EN defined: the saturated result r is output as max(r, 0). Negative results give output_data=0.
- FC_RELU_EN undefined: the saturated result is output unchanged (linear layer).
- No other behaviour changes; latency is identical in both builds.

## Test plan
- M=4,N=2,P=2,FRAC=0; all W=1, all b=0; x=[3,4] → y=7,7,7,7; first output_valid exactly 4 cycles after the 2nd x handshake.
- All W=32767, b=32767, x=[32767,32767] → every y=32767. Negate W and b → every y=−32768 (without FC_RELU_EN) or 0 (with FC_RELU_EN).
- W row r = [−1,−1], b=0, x=[3,4] → y=−7 without FC_RELU_EN; y=0 with FC_RELU_EN.
- FRAC=8, W[0][0]=256, W[0][1]=0, b[0]=256, x=[512,9] → y[0]=768.
- output_ready low for 5 cycles after first output_valid → output_data held constant, input_ready=0 throughout; all 4 y values emerge in order with none lost or duplicated.
- reset=0 for one cycle during MAC → next cycle output_valid=0, w_ready=1, input_ready=0. Reload new W, send x → outputs reflect new weights only. reload=1 in LOAD_X before any x → w_ready=1 next cycle.
